// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator for the word-addressed data memory of the
// RVX10 MEM stage. Each request is a single byte, half or word access.
// Loads are extended to 32 bits. Sub-word stores are built by reading the
// word, merging the new lane(s) and writing the word back.
// Misaligned accesses and illegal funct3 codes finish with resp_err set and
// never write memory.

module dmem_lsu #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state, state_next;

    logic          we_q;
    logic [2:0]    funct3_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   merged_q;

    logic          accept;
    logic          illegal;
    logic          misaligned;
    logic          err;
    logic          is_word;
    logic          store_word;
    logic          store_sub;
    logic [7:0]    load_byte;
    logic [15:0]   load_half;
    logic [31:0]   load_data;
    logic [31:0]   merged_next;

    assign accept = (state == IDLE) && req_valid;

    // The memory only sees word addresses; the byte offset stays inside the LSU
    // so mem_a keeps its last value whenever no access is in progress.
    assign mem_a  = {addr_q[AW-1:2], 2'b00};

    // Decode the captured request: legality, alignment and store flavour.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        is_word    = (funct3_q[1:0] == 2'b10);
        if (funct3_q[1:0] == 2'b11) begin
            illegal = 1'b1;
        end
        if (funct3_q[2] && (we_q || funct3_q[1])) begin
            illegal = 1'b1;
        end
        if ((funct3_q[1:0] == 2'b01) && addr_q[0]) begin
            misaligned = 1'b1;
        end
        if (is_word && (addr_q[1:0] != 2'b00)) begin
            misaligned = 1'b1;
        end
        err        = illegal || misaligned;
        store_word = we_q && !err && is_word;
        store_sub  = we_q && !err && !is_word;
    end

    // Pick the addressed lane(s) out of the read word and extend them; the
    // unsigned variants (funct3[2]=1) zero-extend.
    always_comb begin
        load_byte = 8'h00;
        load_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        load_data = mem_rd;
        case (addr_q[1:0])
            2'd0:    load_byte = mem_rd[7:0];
            2'd1:    load_byte = mem_rd[15:8];
            2'd2:    load_byte = mem_rd[23:16];
            default: load_byte = mem_rd[31:24];
        endcase
        case (funct3_q[1:0])
            2'b00:   load_data = {{24{load_byte[7] & ~funct3_q[2]}}, load_byte};
            2'b01:   load_data = {{16{load_half[15] & ~funct3_q[2]}}, load_half};
            default: load_data = mem_rd;
        endcase
    end

    // Replace the addressed byte or half of the current word with store data.
    always_comb begin
        merged_next = mem_rd;
        if (funct3_q[1:0] == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged_next[7:0]   = wdata_q[7:0];
                2'd1:    merged_next[15:8]  = wdata_q[7:0];
                2'd2:    merged_next[23:16] = wdata_q[7:0];
                default: merged_next[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged_next[31:16] = wdata_q[15:0];
        end else begin
            merged_next[15:0] = wdata_q[15:0];
        end
    end

    // Next-state and handshake/memory strobes. Strobes are masked during reset
    // so an aborted sub-word store never reaches memory and no response leaks.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        mem_wd     = merged_q;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_wd = wdata_q;
                mem_we = store_word && !reset;
                state_next = store_sub ? WRITE : RESP;
            end
            WRITE: begin
                mem_we     = !reset;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = !reset;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture, merge buffer and the response registers, which only
    // change on the way into RESP so they hold between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            merged_q   <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (state == ACCESS) begin
                if (err) begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b1;
                end else if (!we_q) begin
                    resp_rdata <= load_data;
                    resp_err   <= 1'b0;
                end else if (store_word) begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                end else begin
                    merged_q <= merged_next;
                end
            end
            if (state == WRITE) begin
                resp_rdata <= 32'h0;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule
